instr_prefetch_buf: RTL and testbench



---
 rtl/instr_prefetch_buf_pkg.sv | 13 +
 rtl/instr_prefetch_buf_if.sv | 15 +
 rtl/instr_prefetch_buf_fetch_fifo.sv | 61 ++++++
 rtl/instr_prefetch_buf.sv | 112 +++++++++++
 tb/tb_instr_prefetch_buf.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_prefetch_buf_pkg.sv
// Shared widths, reset pc default and fetch FSM encodings for the prefetch buffer.
package instr_prefetch_buf_pkg;

    localparam int          IPB_ADDR_WIDTH  = 32;
    localparam int          IPB_INSTR_WIDTH = 32;
    localparam int          IPB_DEPTH       = 4;
    localparam logic [31:0] IPB_RESET_PC    = 32'h0;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/instr_prefetch_buf_if.sv
// Decode-side valid/ready channel carrying {pc, instr} pairs.
interface instr_prefetch_buf_if
    import instr_prefetch_buf_pkg::*;
#(
    parameter int ADDR_WIDTH  = IPB_ADDR_WIDTH,
    parameter int INSTR_WIDTH = IPB_INSTR_WIDTH
);
    logic                   dec_valid;
    logic                   dec_ready;
    logic [INSTR_WIDTH-1:0] dec_instr;
    logic [ADDR_WIDTH-1:0]  dec_pc;

    modport master (output dec_valid, output dec_instr, output dec_pc, input dec_ready);
    modport slave  (input dec_valid, input dec_instr, input dec_pc, output dec_ready);
endinterface

// File: rtl/instr_prefetch_buf_fetch_fifo.sv
// Purpose: generic synchronous FIFO with wrapping pointers, occupancy count and sync clear.
// Latency: registered storage, a pushed entry is visible at the head the next cycle.
// Backpressure: push is dropped when full unless a pop frees the slot in the same cycle.
module instr_prefetch_buf_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot before the write lands.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge cpu_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_prefetch_buf.sv
// Purpose: fetch front end owning pc/next_pc, buffering {pc, instr} for decode.
// Latency: response at cycle N appears on dec_valid at N+1; redirect squashes one cycle.
// Backpressure: full FIFO stalls fetch, responses are dropped and the same pc is re-read.
module instr_prefetch_buf
    import instr_prefetch_buf_pkg::*;
#(
    parameter int                    DEPTH       = IPB_DEPTH,
    parameter int                    ADDR_WIDTH  = IPB_ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = IPB_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(IPB_RESET_PC),
    parameter int                    CW          = $clog2(DEPTH) + 1
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst,
    output logic [ADDR_WIDTH-1:0]  next_pc,
    output logic [ADDR_WIDTH-1:0]  pc,
    input  logic [INSTR_WIDTH-1:0] instr_read_data,
    input  logic                   instr_read_data_valid,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    instr_prefetch_buf_if.master   dec,
    output logic [CW-1:0]          fifo_count
);
    localparam int                    EW       = ADDR_WIDTH + INSTR_WIDTH;
    localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] PC_ALIGN = ~ADDR_WIDTH'(3);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  accept;
    logic                  pop;
    logic                  fifo_empty;
    logic [EW-1:0]         head_dat;
    logic [CW-1:0]         count_post;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] redirect_aligned;

    assign accept           = instr_read_data_valid && (state_q == ST_FETCH) && !redirect;
    assign pop              = !fifo_empty && dec.dec_ready && !redirect;
    assign pc_inc           = pc + PC_STEP;
    assign redirect_aligned = redirect_pc & PC_ALIGN;

    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = redirect_aligned;
        end else if (accept) begin
            next_pc = pc_inc;
        end
    end

    // pc only ever moves to next_pc, so the memory side sees the same address one cycle early.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    always_comb begin
        count_post = fifo_count;
        if (accept && !pop) begin
            count_post = fifo_count + 1'b1;
        end else if (pop && !accept) begin
            count_post = fifo_count - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_FETCH: state_d = (count_post == FULL_CNT) ? ST_STALL : ST_FETCH;
                ST_STALL: state_d = (count_post <  FULL_CNT) ? ST_FETCH : ST_STALL;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    instr_prefetch_buf_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fetch_fifo (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .clr      (redirect),
        .push     (accept),
        .push_dat ({pc, instr_read_data}),
        .pop      (pop),
        .pop_dat  (head_dat),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Head is zeroed while empty so decode never sees stale storage.
    assign dec.dec_valid = !fifo_empty;
    assign dec.dec_pc    = fifo_empty ? '0 : head_dat[EW-1:INSTR_WIDTH];
    assign dec.dec_instr = fifo_empty ? '0 : head_dat[INSTR_WIDTH-1:0];
endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Directed bench for instr_prefetch_buf; expected dec_pc order is queued by stimulus, checked by a monitor.
module tb_instr_prefetch_buf;
    localparam int          AW     = 32;
    localparam int          IW     = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h100;
    localparam logic [31:0] IMASK  = 32'hDEAD_0000;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst;
    logic [AW-1:0] next_pc;
    logic [AW-1:0] pc;
    logic [IW-1:0] instr_read_data;
    logic          instr_read_data_valid;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [2:0]    fifo_count;

    instr_prefetch_buf_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dec_if ();

    instr_prefetch_buf #(
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .RESET_PC    (RST_PC)
    ) dut (
        .cpu_clk               (cpu_clk),
        .cpu_rst               (cpu_rst),
        .next_pc               (next_pc),
        .pc                    (pc),
        .instr_read_data       (instr_read_data),
        .instr_read_data_valid (instr_read_data_valid),
        .redirect              (redirect),
        .redirect_pc           (redirect_pc),
        .dec                   (dec_if.master),
        .fifo_count            (fifo_count)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Instruction memory: content is a fixed function of the address being fetched.
    assign instr_read_data = pc ^ IMASK;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge cpu_clk);
        #1;
    endtask

    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc    = '0;
    logic [31:0] prev_instr = '0;

    always @(negedge cpu_clk) begin
        if (!cpu_rst && prev_stall && dec_if.dec_valid) begin
            check("hold_pc", dec_if.dec_pc, prev_pc);
            check("hold_instr", dec_if.dec_instr, prev_instr);
        end
        if (!cpu_rst && dec_if.dec_valid && dec_if.dec_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pop: got dec_pc %h want none", dec_if.dec_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("dec_pc", dec_if.dec_pc, e);
                check("dec_instr", dec_if.dec_instr, e ^ IMASK);
            end
        end
        prev_stall = !cpu_rst && dec_if.dec_valid && !dec_if.dec_ready && !redirect;
        prev_pc    = dec_if.dec_pc;
        prev_instr = dec_if.dec_instr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cpu_rst               = 1'b1;
        instr_read_data_valid = 1'b0;
        redirect              = 1'b0;
        redirect_pc           = '0;
        dec_if.dec_ready      = 1'b1;
        cyc();
        cyc();
        check("rst_pc", pc, RST_PC);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_dec_valid", 32'(dec_if.dec_valid), 0);
        check("rst_dec_pc", dec_if.dec_pc, 0);
        check("rst_dec_instr", dec_if.dec_instr, 0);

        // Streaming with decode always ready: one entry in flight at most.
        cpu_rst = 1'b0;
        instr_read_data_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(RST_PC + 32'(4 * i));
            cyc();
            check("t1_pc", pc, RST_PC + 32'(4 * (i + 1)));
            check("t1_count_le1", 32'(fifo_count <= 3'd1), 1);
        end
        instr_read_data_valid = 1'b0;
        cyc();
        cyc();
        check("t1_drain_count", 32'(fifo_count), 0);
        check("t1_pc_hold", pc, 32'h118);

        // Fill to full with decode stalled, then release.
        cpu_rst = 1'b1;
        exp_q.delete();
        cyc();
        cpu_rst = 1'b0;
        dec_if.dec_ready = 1'b0;
        instr_read_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(RST_PC + 32'(4 * i));
        repeat (7) cyc();
        check("t2_full_count", 32'(fifo_count), 4);
        check("t2_stall_pc", pc, 32'h110);
        check("t2_stall_next_pc", next_pc, 32'h110);
        check("t2_head_pc", dec_if.dec_pc, 32'h100);
        dec_if.dec_ready = 1'b1;
        exp_q.push_back(32'h110);
        exp_q.push_back(32'h114);
        exp_q.push_back(32'h118);
        repeat (4) cyc();
        check("t2_resume_count", 32'(fifo_count), 3);
        check("t2_resume_pc", pc, 32'h11C);
        instr_read_data_valid = 1'b0;
        repeat (4) cyc();
        check("t2_drain_count", 32'(fifo_count), 0);
        check("t2_drain_q", 32'(exp_q.size()), 0);

        // Simultaneous push and pop at occupancy 3, then reset with entries buffered.
        cpu_rst = 1'b1;
        exp_q.delete();
        cyc();
        cpu_rst = 1'b0;
        dec_if.dec_ready = 1'b0;
        instr_read_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(RST_PC + 32'(4 * i));
        repeat (3) cyc();
        check("t3_count3", 32'(fifo_count), 3);
        dec_if.dec_ready = 1'b1;
        cyc();
        check("t3_pushpop_count", 32'(fifo_count), 3);
        check("t3_pushpop_head", dec_if.dec_pc, 32'h104);
        dec_if.dec_ready = 1'b0;
        instr_read_data_valid = 1'b0;
        cpu_rst = 1'b1;
        exp_q.delete();
        cyc();
        check("t6_rst_dec_valid", 32'(dec_if.dec_valid), 0);
        check("t6_rst_count", 32'(fifo_count), 0);
        check("t6_rst_pc", pc, RST_PC);
        cpu_rst = 1'b0;
        dec_if.dec_ready = 1'b1;
        instr_read_data_valid = 1'b1;
        #1;
        check("t6_fetch_next_pc", next_pc, 32'h104);
        exp_q.push_back(32'h100);
        cyc();
        instr_read_data_valid = 1'b0;
        cyc();

        // Redirect to an unaligned target with responses on both squash cycles.
        instr_read_data_valid = 1'b1;
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        #1;
        check("t4_next_pc_align", next_pc, 32'h200);
        cyc();
        redirect = 1'b0;
        check("t4_flush_count", 32'(fifo_count), 0);
        check("t4_flush_dec_valid", 32'(dec_if.dec_valid), 0);
        check("t4_flush_pc", pc, 32'h200);
        cyc();
        check("t4_drop_count", 32'(fifo_count), 0);
        check("t4_drop_pc", pc, 32'h200);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        cyc();
        cyc();
        instr_read_data_valid = 1'b0;
        cyc();
        cyc();
        check("t4_pc", pc, 32'h208);

        // pc wrap at the top of the address space.
        instr_read_data_valid = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        cyc();
        redirect = 1'b0;
        cyc();
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        cyc();
        check("t5_wrap_pc", pc, 32'h0);
        cyc();
        instr_read_data_valid = 1'b0;
        check("t5_pc", pc, 32'h4);
        cyc();
        cyc();

        // Back-to-back redirects: the second one restarts the squash with its target.
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        cyc();
        redirect_pc = 32'h400;
        instr_read_data_valid = 1'b1;
        cyc();
        redirect = 1'b0;
        check("t7_pc", pc, 32'h400);
        check("t7_count", 32'(fifo_count), 0);
        cyc();
        check("t7_drop_count", 32'(fifo_count), 0);
        exp_q.push_back(32'h400);
        cyc();
        instr_read_data_valid = 1'b0;
        cyc();
        cyc();
        check("t7_final_pc", pc, 32'h404);
        check("final_q_empty", 32'(exp_q.size()), 0);
        check("final_count", 32'(fifo_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
